computie_bus_sequencer: RTL
===========================

# computie_bus_sequencer

Bus-cycle sequencer that sits directly behind `computie_bus_io`. It turns single-word read/write requests from internal logic into multiplexed address/data cycles on the narrow `pins_ad` bus. It does this by driving `out_data` and `output_enable` into the pad block and sampling its registered `in_data`. It generates address and data strobes, waits for a synchronized DTACK or BERR, or times out, and returns one response per request.

## Interface
- `AD_WIDTH`, 8: width of the multiplexed bus; must match `computie_bus_io`.
- `ADDR_WIDTH`, 24: request address width; must be a multiple of `AD_WIDTH`.
- `DATA_WIDTH`, 16: data word width; must be a multiple of `AD_WIDTH`.
- `TIMEOUT_CYCLES`, 255: number of WAIT cycles before the cycle is aborted with an error; range 1..255.

Ports (name, direction, width, meaning):
- `clk_16M`, in, 1: the single clock; all logic is on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, 1: a request is present.
- `req_ready`, out, 1: the sequencer can accept a request.
- `req_write`, in, 1: 1 = write, 0 = read.
- `req_addr`, in, ADDR_WIDTH: request address.
- `req_wdata`, in, DATA_WIDTH: write data.
- `resp_valid`, out, 1: one-cycle pulse marking completion.
- `resp_error`, out, 1: qualified by `resp_valid`; 1 = BERR or timeout.
- `resp_rdata`, out, DATA_WIDTH: read data, held stable until the next read completes.
- `bus_output_enable`, out, 1: drives `output_enable` of the pad block.
- `bus_out_data`, out, AD_WIDTH: drives `out_data` of the pad block.
- `bus_in_data`, in, AD_WIDTH: the pad block's registered `in_data`.
- `bus_as_n`, out, 1: address strobe, active low.
- `bus_ds_n`, out, 1: data strobe, active low.
- `bus_rw`, out, 1: 1 = read, 0 = write.
- `bus_dtack_n`, in, 1: asynchronous slave acknowledge, active low.
- `bus_berr_n`, in, 1: asynchronous bus error, active low.

## Operation
- Derived counts: `AB = ADDR_WIDTH/AD_WIDTH` address beats and `DB = DATA_WIDTH/AD_WIDTH` data beats. All beats are sent or received most-significant first.
- `bus_dtack_n` and `bus_berr_n` each pass through a 2-flop synchronizer. Both synchronizers reset to 1. The state machine uses only the synchronized values.
- A request is accepted on a clock edge where `req_valid & req_ready`. Address, data and direction are latched on that edge; later changes on the `req_*` inputs are ignored.
- States:
  - **IDLE**: `req_ready`=1. All strobes high, `bus_output_enable`=0, `bus_rw`=1. On accept → ADDR.
  - **ADDR**: `bus_output_enable`=1, `bus_as_n`=0, `bus_rw` = !write. One address beat per cycle for AB cycles. After the last beat: write → WDATA, read → TURN.
  - **WDATA**: `bus_output_enable`=1, `bus_as_n`=0, `bus_ds_n`=0. One data beat per cycle for DB cycles, then → WAIT.
  - **TURN** (read only): one cycle with `bus_output_enable`=0, `bus_as_n`=0, `bus_ds_n`=0, then → WAIT.
  - **WAIT**: `bus_output_enable`=0, `bus_as_n`=0, `bus_ds_n`=0. Exits, in priority order:
    - BERR low → DONE with error.
    - DTACK low: write → DONE; read → RDATA.
    - Wait counter reaches TIMEOUT_CYCLES → DONE with error.
  - **RDATA**: strobes stay low. `bus_in_data` is shifted into the read register on each of the DB cycles that follow the WAIT exit, then → DONE.
  - **DONE**: all strobes high, `bus_output_enable`=0. `resp_valid`=1 on the first DONE cycle only. Stays in DONE until synchronized DTACK and BERR are both high, then → IDLE.
- `resp_rdata` updates only on a successful read. On an error it keeps its previous value.
- `bus_out_data` is 0 whenever `bus_output_enable`=0.
- The wait counter is 8 bits, cleared on entry to WAIT, and saturates.

## Timing
- Reset values (applied asynchronously):
  - state = IDLE; all counters = 0.
  - `req_ready`=1, `resp_valid`=0, `resp_error`=0, `resp_rdata`=0.
  - `bus_output_enable`=0, `bus_out_data`=0, `bus_as_n`=1, `bus_ds_n`=1, `bus_rw`=1.
- Reset asserted mid-cycle releases all strobes and the bus immediately, and no response is issued.
- All outputs are registered. `req_ready` is 0 from the cycle after an accept until IDLE is re-entered.
- Accept at edge 0 means ADDR occupies cycles 1..AB.
- Synchronizer delay: a slave input that goes low before edge n is seen by the state machine in the cycle after edge n+1.
- Minimum write latency (accept → `resp_valid`), with DTACK already low: AB + DB + 3 cycles. For defaults this is 8.
- Minimum read latency: AB + 1 + 2 + DB + 1. For defaults this is 9.
- Back-to-back requests are separated by at least one IDLE cycle.

## Test plan
- Write of `addr`=0x123456, `data`=0xBEEF, with DTACK low from the first WAIT cycle:
  - `bus_out_data` shows 12, 34, 56, BE, EF on consecutive cycles with `bus_as_n`=0 and `bus_rw`=0.
  - `resp_valid` with `resp_error`=0 arrives 8 cycles after accept.
- Read of `addr`=0x00A000, with the slave supplying 0xCA then 0xFE after DTACK:
  - `bus_output_enable`=0 from TURN onward.
  - `resp_rdata`=0xCAFE and `resp_error`=0.
- Read with DTACK never asserted:
  - After 255 WAIT cycles, `resp_valid`=1 and `resp_error`=1.
  - `resp_rdata` is unchanged.
- BERR and DTACK asserted low on the same cycle during WAIT:
  - Error response, no RDATA state, strobes released.
- DTACK held low after completion:
  - The block stays in DONE with `req_ready`=0 until DTACK is released, then returns to IDLE.
- `reset` pulsed during WDATA:
  - Within the same cycle, `bus_as_n`/`bus_ds_n`=1 and `bus_output_enable`=0.
  - No `resp_valid`.
  - The next request completes normally.

Source files
------------

// File: rtl/computie_bus_sequencer_if.sv
// Request/response and pad-side signals of the bus-cycle sequencer.
// The sequencer uses the slave modport; the requester and the pad block use master.
interface computie_bus_sequencer_if #(
  parameter int AD_WIDTH   = 8,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_error;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  bus_output_enable;
  logic [AD_WIDTH-1:0]   bus_out_data;
  logic [AD_WIDTH-1:0]   bus_in_data;
  logic                  bus_as_n;
  logic                  bus_ds_n;
  logic                  bus_rw;
  logic                  bus_dtack_n;
  logic                  bus_berr_n;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output bus_in_data, bus_dtack_n, bus_berr_n,
    input  req_ready, resp_valid, resp_error, resp_rdata,
    input  bus_output_enable, bus_out_data, bus_as_n, bus_ds_n, bus_rw
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  bus_in_data, bus_dtack_n, bus_berr_n,
    output req_ready, resp_valid, resp_error, resp_rdata,
    output bus_output_enable, bus_out_data, bus_as_n, bus_ds_n, bus_rw
  );
endinterface

// File: rtl/computie_bus_sequencer.sv
// Turns single-word requests into multiplexed address/data cycles on the narrow pad bus,
// waits for synchronized DTACK/BERR or a timeout, and returns one response per request.
module computie_bus_sequencer #(
  parameter int AD_WIDTH       = 8,
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_16M,
  input  logic                    reset,
  computie_bus_sequencer_if.slave io
);
  localparam int AB = ADDR_WIDTH / AD_WIDTH;
  localparam int DB = DATA_WIDTH / AD_WIDTH;
  localparam logic [8:0] TMO = 9'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_TURN, S_WAIT, S_RDATA, S_DONE} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rd_q, rdata_q;
  logic                  write_q;
  logic [7:0]            beat_q, wait_q;
  logic                  dt_meta_q, dt_q, be_meta_q, be_q;
  logic                  ready_q, resp_valid_q, resp_error_q;
  logic                  oe_q, as_n_q, ds_n_q, rw_q;
  logic [AD_WIDTH-1:0]   out_q;

  logic [8:0]            wait_d;
  logic [DATA_WIDTH-1:0] rd_d;
  logic                  ack_ok, wait_exit, wait_err, go_done;

  assign wait_d = {1'b0, wait_q} + 9'd1;
  assign rd_d   = (rd_q << AD_WIDTH) | DATA_WIDTH'(io.bus_in_data);
  // The first WAIT cycle gives the slave one cycle of asserted strobes before an acknowledge counts.
  assign ack_ok = (wait_q != 8'd0);

  always_comb begin
    wait_exit = 1'b0;
    wait_err  = 1'b0;
    if (state_q == S_WAIT) begin
      if (ack_ok && !be_q) begin
        wait_exit = 1'b1;
        wait_err  = 1'b1;
      end else if (ack_ok && !dt_q) begin
        wait_exit = 1'b1;
      end else if (wait_d >= TMO) begin
        wait_exit = 1'b1;
        wait_err  = 1'b1;
      end
    end
  end

  assign go_done = (wait_exit && (wait_err || write_q)) ||
                   (state_q == S_RDATA && beat_q == 8'(DB - 1));

  always_ff @(posedge clk_16M or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      rdata_q      <= '0;
      write_q      <= 1'b0;
      beat_q       <= '0;
      wait_q       <= '0;
      dt_meta_q    <= 1'b1;
      dt_q         <= 1'b1;
      be_meta_q    <= 1'b1;
      be_q         <= 1'b1;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      oe_q         <= 1'b0;
      out_q        <= '0;
      as_n_q       <= 1'b1;
      ds_n_q       <= 1'b1;
      rw_q         <= 1'b1;
    end else begin
      dt_meta_q    <= io.bus_dtack_n;
      dt_q         <= dt_meta_q;
      be_meta_q    <= io.bus_berr_n;
      be_q         <= be_meta_q;
      resp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (io.req_valid && ready_q) begin
          addr_q  <= io.req_addr << AD_WIDTH;
          out_q   <= io.req_addr[ADDR_WIDTH-1 -: AD_WIDTH];
          wdata_q <= io.req_wdata;
          write_q <= io.req_write;
          rw_q    <= !io.req_write;
          oe_q    <= 1'b1;
          as_n_q  <= 1'b0;
          ready_q <= 1'b0;
          beat_q  <= '0;
          state_q <= S_ADDR;
        end
        S_ADDR: begin
          if (beat_q == 8'(AB - 1)) begin
            beat_q <= '0;
            ds_n_q <= 1'b0;
            if (write_q) begin
              out_q   <= wdata_q[DATA_WIDTH-1 -: AD_WIDTH];
              wdata_q <= wdata_q << AD_WIDTH;
              state_q <= S_WDATA;
            end else begin
              oe_q    <= 1'b0;
              out_q   <= '0;
              state_q <= S_TURN;
            end
          end else begin
            beat_q <= beat_q + 8'd1;
            out_q  <= addr_q[ADDR_WIDTH-1 -: AD_WIDTH];
            addr_q <= addr_q << AD_WIDTH;
          end
        end
        S_WDATA: begin
          if (beat_q == 8'(DB - 1)) begin
            oe_q    <= 1'b0;
            out_q   <= '0;
            wait_q  <= '0;
            state_q <= S_WAIT;
          end else begin
            beat_q  <= beat_q + 8'd1;
            out_q   <= wdata_q[DATA_WIDTH-1 -: AD_WIDTH];
            wdata_q <= wdata_q << AD_WIDTH;
          end
        end
        S_TURN: begin
          wait_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!wait_exit) begin
            wait_q <= (wait_q == 8'hFF) ? wait_q : wait_d[7:0];
          end else if (!go_done) begin
            beat_q  <= '0;
            state_q <= S_RDATA;
          end
        end
        S_RDATA: begin
          rd_q   <= rd_d;
          beat_q <= beat_q + 8'd1;
          if (go_done) rdata_q <= rd_d;
        end
        S_DONE: if (dt_q && be_q) begin
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
      if (go_done) begin
        state_q      <= S_DONE;
        as_n_q       <= 1'b1;
        ds_n_q       <= 1'b1;
        rw_q         <= 1'b1;
        resp_valid_q <= 1'b1;
        resp_error_q <= wait_err;
      end
    end
  end

  assign io.req_ready         = ready_q;
  assign io.resp_valid        = resp_valid_q;
  assign io.resp_error        = resp_error_q;
  assign io.resp_rdata        = rdata_q;
  assign io.bus_output_enable = oe_q;
  assign io.bus_out_data      = out_q;
  assign io.bus_as_n          = as_n_q;
  assign io.bus_ds_n          = ds_n_q;
  assign io.bus_rw            = rw_q;
endmodule
